// File: rtl/imm_pkg.sv
// ---------------------------------------------------------------------------
// imm_pkg
// Shared definitions for immediate packing. The ImmSrc codes match the ones
// used by the decode-side immediate extraction, so both directions agree on
// format numbering.
//   - IMM_* : ImmSrc format codes (110/111 are illegal)
//   - *_LSB : bit positions of the immediate fields in the instruction word
//   - fifo_entry_t : one queued output word (encoded instruction + error flag)
// ---------------------------------------------------------------------------
package imm_pkg;

  localparam logic [2:0] IMM_I   = 3'b000;
  localparam logic [2:0] IMM_S   = 3'b001;
  localparam logic [2:0] IMM_B   = 3'b010;
  localparam logic [2:0] IMM_J   = 3'b011;
  localparam logic [2:0] IMM_U   = 3'b100;
  localparam logic [2:0] IMM_CSR = 3'b101;

  // Instruction-word positions of the immediate fields.
  localparam int I_LSB     = 20;  // I: [31:20]
  localparam int S_HI_LSB  = 25;  // S/B upper field starts here
  localparam int S_LO_LSB  = 7;   // S: [11:7], B: [11:8] + bit 7
  localparam int B_BIT11   = 7;   // B: imm[11] lives in bit 7
  localparam int J_BIT11   = 20;  // J: imm[11] lives in bit 20
  localparam int J_LO_LSB  = 21;  // J: imm[10:1] in [30:21]
  localparam int U_LSB     = 12;  // U: [31:12]; J: imm[19:12] in [19:12]
  localparam int CSR_LSB   = 15;  // CSR-imm: [19:15] (the rs1 slot)

  typedef struct packed {
    logic        err;
    logic [31:0] instr;
  } fifo_entry_t;

endpackage

// File: rtl/imm_pack.sv
// ---------------------------------------------------------------------------
// imm_pack
// Purely combinational: scatters an immediate into the RISC-V encoding
// positions of the selected format on top of an instruction template.
// Template bits outside the immediate field pass through unchanged.
// Ports:
//   imm_src [2:0]  format code (imm_pkg::IMM_*); 110/111 flag err
//   base   [31:0]  instruction template
//   imm    [31:0]  immediate (two's complement, zero-extended for CSR-imm)
//   instr  [31:0]  packed instruction word
//   err            illegal format, or (with IMM_RANGE_CHECK_EN defined)
//                  an immediate that the format cannot represent exactly.
// Build option: IMM_RANGE_CHECK_EN enables the representability check. The
// word is always packed by truncation either way.
// ---------------------------------------------------------------------------
module imm_pack
  import imm_pkg::*;
(
  input  logic [2:0]  imm_src,
  input  logic [31:0] base,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        err
);

  logic illegal;
  logic range_err;

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // it unassigned; that is what keeps this block free of inferred latches.
    instr   = base;
    illegal = 1'b0;
    unique case (imm_src)
      IMM_I: instr[31:I_LSB] = imm[11:0];
      IMM_S: begin
        instr[31:S_HI_LSB]         = imm[11:5];
        instr[S_LO_LSB+4:S_LO_LSB] = imm[4:0];
      end
      IMM_B: begin
        instr[31]                    = imm[12];
        instr[30:S_HI_LSB]           = imm[10:5];
        instr[S_LO_LSB+4:S_LO_LSB+1] = imm[4:1];
        instr[B_BIT11]               = imm[11];
      end
      IMM_J: begin
        instr[31]             = imm[20];
        instr[30:J_LO_LSB]    = imm[10:1];
        instr[J_BIT11]        = imm[11];
        instr[19:U_LSB]       = imm[19:12];
      end
      IMM_U:   instr[31:U_LSB]           = imm[31:U_LSB];
      IMM_CSR: instr[CSR_LSB+4:CSR_LSB]  = imm[4:0];
      default: illegal = 1'b1;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  // Sign-extension checks: the bits above the field's top bit must all be
  // copies of it, and branch/jump offsets must be halfword aligned.
  always_comb begin
    range_err = 1'b0;
    unique case (imm_src)
      IMM_I, IMM_S: range_err = !((&imm[31:11]) || !(|imm[31:11]));
      IMM_B:        range_err = imm[0] || !((&imm[31:12]) || !(|imm[31:12]));
      IMM_J:        range_err = imm[0] || !((&imm[31:20]) || !(|imm[31:20]));
      IMM_U:        range_err = |imm[11:0];
      IMM_CSR:      range_err = |imm[31:5];
      default:      range_err = 1'b0;
    endcase
  end
`else
  assign range_err = 1'b0;
`endif

  assign err = illegal | range_err;

endmodule

// File: rtl/imm_encoder.sv
// ---------------------------------------------------------------------------
// imm_encoder
// Packs immediates into instruction templates (via imm_pack) and queues the
// results in a first-word-fall-through FIFO for the debug program buffer /
// instruction-injection path.
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   in_valid/in_ready request handshake; in_ready = !full (registered state)
//   in_ImmSrc [2:0]   format code
//   in_base   [31:0]  instruction template
//   in_imm    [31:0]  immediate
//   out_valid/out_ready  head handshake
//   out_instr [31:0], out_err   head entry
//   out_level         occupancy, 0..DEPTH
// Parameter: DEPTH (power of two, >= 2).
// Build option: IMM_RANGE_CHECK_EN (see imm_pack).
// ---------------------------------------------------------------------------
module imm_encoder
  import imm_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_ImmSrc,
  input  logic [31:0]              in_base,
  input  logic [31:0]              in_imm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic                     out_err,
  output logic [$clog2(DEPTH):0]   out_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [31:0] packed_instr;
  logic        packed_err;

  imm_pack u_pack (
    .imm_src (in_ImmSrc),
    .base    (in_base),
    .imm     (in_imm),
    .instr   (packed_instr),
    .err     (packed_err)
  );

  // One extra pointer bit distinguishes full from empty when the index bits
  // are equal.
  logic [PW-1:0] wr_ptr, rd_ptr;
  fifo_entry_t   mem [DEPTH];
  fifo_entry_t   head;
  logic          full, empty, push, pop;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign push  = in_valid && !full;
  assign pop   = !empty && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage has no reset; an entry is only observed after it has been
  // written, and leaving it out keeps the array mappable to plain RAM/flops
  // without a reset tree.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= '{err: packed_err, instr: packed_instr};
  end

  assign head      = mem[rd_ptr[AW-1:0]];
  assign out_instr = head.instr;
  assign out_err   = head.err;
  assign out_valid = !empty;
  assign in_ready  = !full;
  assign out_level = wr_ptr - rd_ptr;

endmodule
